// File: rtl/parity.sv
// parity: configurable-width even/odd parity generator and checker.
//
// Every cycle the parity bit of data_in (sense chosen by even_odd) is
// registered onto par_out. When in_valid is high the same bit is compared
// against par_in, and any mismatch is registered onto par_err. All outputs
// come from flops, so there is no combinational input-to-output path, and
// the latency is exactly one clock.
//
// Valid semantics: in_valid qualifies data_in/par_in on the edge where it is
// sampled. out_valid is in_valid delayed by one clock and qualifies
// par_out/par_err. There is no ready; the block accepts every cycle.
//
// Optional build macro PARITY_STICKY_ERR_EN adds err_clr/err_sticky. This is
// a sticky error flag that is set by any registered mismatch and cleared by
// err_clr. If a set and a clear happen on the same edge, the set wins.
module parity #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             even_odd,
    input  logic             in_valid,
    input  logic             par_in,
`ifdef PARITY_STICKY_ERR_EN
    input  logic             err_clr,
    output logic             err_sticky,
`endif
    output logic             par_out,
    output logic             out_valid,
    output logic             par_err
);

    // Parity bit of the current word.
    // The data XOR is inverted for odd sense so that the total number of ones
    // is odd. The mismatch is gated by in_valid, so par_in is ignored (even if
    // it is X) when in_valid is low.
    logic p_next;
    logic err_next;

    // Combinational parity and mismatch for the word sampled at the next edge.
    always_comb begin
        p_next   = (^data_in) ^ even_odd;
        err_next = in_valid & (p_next != par_in);
    end

    // Output registers. Reset clears them asynchronously, which drops any result still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_out   <= 1'b0;
            out_valid <= 1'b0;
            par_err   <= 1'b0;
        end else begin
            par_out   <= p_next;
            out_valid <= in_valid;
            par_err   <= err_next;
        end
    end

`ifdef PARITY_STICKY_ERR_EN
    // Sticky error flag. A new mismatch takes priority over a clear on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else begin
            err_sticky <= err_next | (err_sticky & ~err_clr);
        end
    end
`endif

endmodule

// File: tb/tb_parity.sv
// tb_parity: randomized and directed bench for parity.
// The reference model derives the parity from a population count.
// Directed steps also pin the outputs to hand-computed literals.
// Defining PARITY_STICKY_ERR_EN also exercises the sticky error flag.
module tb_parity;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] data_in;
    logic         even_odd;
    logic         in_valid;
    logic         par_in;
    logic         err_clr;
    logic         err_sticky;
    logic         par_out;
    logic         out_valid;
    logic         par_err;

    int total = 0;
    int bad   = 0;

    // Expected entry: {sticky, par_out, out_valid, par_err}
    logic [3:0] exp_q[$];
    logic       model_sticky;
    logic [3:0] cmp_e;

    parity #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .even_odd  (even_odd),
        .in_valid  (in_valid),
        .par_in    (par_in),
`ifdef PARITY_STICKY_ERR_EN
        .err_clr   (err_clr),
        .err_sticky(err_sticky),
`endif
        .par_out   (par_out),
        .out_valid (out_valid),
        .par_err   (par_err)
    );

`ifndef PARITY_STICKY_ERR_EN
    assign err_sticky = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic logic model_p(input logic [W-1:0] d, input logic eo);
        int ones;
        ones = $countones(d);
        return ((ones % 2) == 1) ? ~eo : eo;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic [W-1:0] d, input logic eo, input logic v,
                        input logic pi, input logic clr);
        logic p;
        logic e;
        @(negedge clk);
        data_in  = d;
        even_odd = eo;
        in_valid = v;
        par_in   = pi;
        err_clr  = clr;
        p = model_p(d, eo);
        e = v && (p != pi);
        model_sticky = e | (model_sticky & ~clr);
        exp_q.push_back({model_sticky, p, v, e});
    endtask

    task automatic step_lit(input string name, input logic [W-1:0] d, input logic eo,
                            input logic v, input logic pi, input logic clr,
                            input logic lit_par, input logic lit_valid, input logic lit_err);
        step(d, eo, v, pi, clr);
        @(posedge clk);
        #2;
        check({name, ".par_out"}, par_out, lit_par);
        check({name, ".out_valid"}, out_valid, lit_valid);
        check({name, ".par_err"}, par_err, lit_err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset.par_out", par_out, 1'b0);
        check("reset.out_valid", out_valid, 1'b0);
        check("reset.par_err", par_err, 1'b0);
`ifdef PARITY_STICKY_ERR_EN
        check("reset.err_sticky", err_sticky, 1'b0);
`endif
        exp_q.delete();
        model_sticky = 1'b0;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- scoreboard compare ----------------
    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            check("sb.par_out", par_out, cmp_e[2]);
            check("sb.out_valid", out_valid, cmp_e[1]);
            check("sb.par_err", par_err, cmp_e[0]);
`ifdef PARITY_STICKY_ERR_EN
            check("sb.err_sticky", err_sticky, cmp_e[3]);
`endif
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        data_in = '0;
        even_odd = 1'b0;
        in_valid = 1'b0;
        par_in = 1'b0;
        err_clr = 1'b0;
        model_sticky = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // First valid result appears one cycle after the first sampled valid.
        step_lit("even_aa", 8'b10101010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step_lit("odd_aa", 8'b10101010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            step_lit("toggle", 8'hAA, i[0], 1'b1, i[0], 1'b0, i[0], 1'b1, 1'b0);
        step_lit("h01_even", 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step_lit("h00_odd", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step_lit("h00_even", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step_lit("hff_even", 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step_lit("hff_odd", 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step_lit("a5_ok", 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step_lit("a5_bad", 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        // par_out still tracks data_in while in_valid is low.
        step_lit("novalid", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef PARITY_STICKY_ERR_EN
        // The a5_bad step above already set the sticky flag; clear it first.
        step_lit("pre_clr", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step_lit("inject", 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("sticky.set", err_sticky, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step_lit("hold", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            check("sticky.hold", err_sticky, 1'b1);
        end
        step_lit("clr", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("sticky.clr", err_sticky, 1'b0);
        step_lit("set_clr", 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("sticky.set_wins", err_sticky, 1'b1);
`endif

        // Mid-stream reset drops an in-flight valid result.
        step(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        do_reset();
        step_lit("post_rst", 8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                @(posedge clk);
                do_reset();
            end
            step(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb.drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
